// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: removes the first N bytes of each AXI-Stream packet,
// presents them LSB-aligned on a header channel, and re-emits the remaining
// payload realigned so its first byte sits in the MSB lane.
// Optional build macro AXIS_STRIP_STATS_EN adds pkt_cnt / short_pkt_cnt outputs.
module axi_stream_strip_header #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header
`ifdef AXIS_STRIP_STATS_EN
  ,
  output logic [15:0]             pkt_cnt,
  output logic [15:0]             short_pkt_cnt
`endif
);

  localparam int unsigned        CNT_WD  = BYTE_CNT_WD + 1;
  localparam logic [CNT_WD-1:0]  W_BYTES = CNT_WD'(DATA_BYTE_WD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HEAD  = 2'd1;
  localparam logic [1:0] S_BODY  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  function automatic logic [DATA_WD-1:0] f_lane_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [CNT_WD-1:0] f_popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CNT_WD-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) c = c + CNT_WD'(k[i]);
    return c;
  endfunction

  // b ones packed against the MSB lane
  function automatic logic [DATA_BYTE_WD-1:0] f_msb_keep(input logic [CNT_WD-1:0] b);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ~(ones >> b);
  endfunction

  // b ones packed against the LSB lane
  function automatic logic [DATA_BYTE_WD-1:0] f_lsb_keep(input logic [CNT_WD-1:0] b);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ~(ones << b);
  endfunction

  logic [1:0]              r_state, w_state_nxt;
  logic [CNT_WD-1:0]       r_n;
  logic [DATA_WD-1:0]      r_resid;
  logic [CNT_WD-1:0]       r_flush_bytes;
  logic                    r_valid_out, r_last_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_hdr_valid;
  logic [DATA_WD-1:0]      r_hdr_data;
  logic [DATA_BYTE_WD-1:0] r_hdr_keep;

  logic                    w_ready_in, w_ready_strip, w_out_ld;
  logic                    w_n_load, w_hdr_load, w_resid_load;
  logic                    w_emit, w_emit_last;
  logic [DATA_WD-1:0]      w_emit_data;
  logic [DATA_BYTE_WD-1:0] w_emit_keep;
  logic [CNT_WD-1:0]       w_k, w_n_clamp, w_hdr_bytes;
  logic                    w_pass, w_k_le_n;
  logic [DATA_WD-1:0]      w_din, w_hdr_data, w_top_n, w_low, w_body_data;

  assign w_k         = f_popcnt(keep_in);
  assign w_din       = data_in & f_lane_mask(keep_in);
  assign w_n_clamp   = (byte_strip_cnt > W_BYTES) ? W_BYTES : byte_strip_cnt;
  assign w_pass      = (r_n == '0);
  assign w_k_le_n    = (w_k <= r_n);
  assign w_hdr_bytes = w_k_le_n ? w_k : r_n;
  assign w_hdr_data  = w_din >> {W_BYTES - w_hdr_bytes, 3'b000};
  assign w_top_n     = w_din >> {W_BYTES - r_n, 3'b000};
  assign w_low       = w_din << {r_n, 3'b000};
  assign w_body_data = r_resid | w_top_n;
  assign w_out_ld    = !r_valid_out || ready_out;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, handshake and emitted-beat decode
  always_comb begin
    w_state_nxt  = r_state;
    w_ready_in   = 1'b0;
    w_ready_strip = 1'b0;
    w_n_load     = 1'b0;
    w_hdr_load   = 1'b0;
    w_resid_load = 1'b0;
    w_emit       = 1'b0;
    w_emit_data  = w_body_data;
    w_emit_keep  = '1;
    w_emit_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready_strip = 1'b1;
        if (valid_strip) begin
          w_n_load    = 1'b1;
          w_state_nxt = S_HEAD;
        end
      end
      S_HEAD: begin
        // N=0 forwards the beat immediately, so it also needs the output slot
        w_ready_in = !r_hdr_valid && (!w_pass || w_out_ld);
        if (valid_in && w_ready_in) begin
          w_hdr_load   = 1'b1;
          w_resid_load = 1'b1;
          if (w_pass) begin
            w_emit      = 1'b1;
            w_emit_data = w_din;
            w_emit_keep = keep_in;
            w_emit_last = last_in;
            w_state_nxt = last_in ? S_IDLE : S_BODY;
          end else if (!last_in) w_state_nxt = S_BODY;
          else if (w_k_le_n)     w_state_nxt = S_IDLE;
          else                   w_state_nxt = S_FLUSH;
        end
      end
      S_BODY: begin
        w_ready_in = w_out_ld;
        if (valid_in && w_ready_in) begin
          w_emit       = 1'b1;
          w_resid_load = 1'b1;
          if (w_pass) begin
            w_emit_data = w_din;
            w_emit_keep = keep_in;
            w_emit_last = last_in;
            if (last_in) w_state_nxt = S_IDLE;
          end else if (last_in) begin
            if (w_k_le_n) begin
              w_emit_keep = f_msb_keep(W_BYTES - r_n + w_k);
              w_emit_last = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (w_out_ld) begin
          w_emit      = 1'b1;
          w_emit_data = r_resid;
          w_emit_keep = f_msb_keep(r_flush_bytes);
          w_emit_last = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strip count, residual, header register and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n           <= '0;
      r_resid       <= '0;
      r_flush_bytes <= '0;
      r_valid_out   <= 1'b0;
      r_data_out    <= '0;
      r_keep_out    <= '0;
      r_last_out    <= 1'b0;
      r_hdr_valid   <= 1'b0;
      r_hdr_data    <= '0;
      r_hdr_keep    <= '0;
    end else begin
      if (w_n_load) r_n <= w_n_clamp;
      if (w_resid_load) begin
        r_resid       <= w_low;
        r_flush_bytes <= w_k - r_n;
      end
      if (r_hdr_valid && ready_header) r_hdr_valid <= 1'b0;
      if (w_hdr_load) begin
        r_hdr_valid <= 1'b1;
        r_hdr_data  <= w_hdr_data;
        r_hdr_keep  <= f_lsb_keep(w_hdr_bytes);
      end
      if (w_out_ld) begin
        r_valid_out <= w_emit;
        if (w_emit) begin
          r_data_out <= w_emit_data & f_lane_mask(w_emit_keep);
          r_keep_out <= w_emit_keep;
          r_last_out <= w_emit_last;
        end
      end
    end
  end

  assign ready_in     = w_ready_in && !rst;
  assign ready_strip  = w_ready_strip && !rst;
  assign valid_out    = r_valid_out;
  assign data_out     = r_data_out;
  assign keep_out     = r_keep_out;
  assign last_out     = r_last_out;
  assign valid_header = r_hdr_valid;
  assign data_header  = r_hdr_data;
  assign keep_header  = r_hdr_keep;

`ifdef AXIS_STRIP_STATS_EN
  logic        w_last_hs, w_short_done;
  logic [15:0] r_pkt_cnt, r_short_cnt;

  assign w_last_hs    = r_valid_out && ready_out && r_last_out;
  assign w_short_done = (r_state == S_HEAD) && valid_in && w_ready_in && last_in &&
                        w_k_le_n && !w_pass;

  // Packet and short-packet counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt   <= '0;
      r_short_cnt <= '0;
    end else begin
      r_pkt_cnt   <= r_pkt_cnt + 16'(w_last_hs) + 16'(w_short_done);
      r_short_cnt <= r_short_cnt + 16'(w_short_done);
    end
  end

  assign pkt_cnt       = r_pkt_cnt;
  assign short_pkt_cnt = r_short_cnt;
`endif

endmodule
